// File: rtl/int_normalize_pipe.sv
// Purpose     : leading-zero normalizer for wide unsigned accumulator words -> mantissa, shift count, sticky.
// Latency     : 3 cycles (capture, count, shift); one word per cycle sustained.
// Backpressure: valid/ready both sides; bubble-collapsing stages, outReady -> inReady is combinational.
//
// Ports:
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   inValid/inReady      input handshake; inData is the WIDTH-bit unsigned word
//   outValid/outReady    output handshake
//   outZero              input word was all zeros
//   outLzc               leading-zero count (WIDTH for a zero word)
//   outMant              top OUT_WIDTH bits of the normalized word (MSB set unless zero)
//   outSticky            OR of the bits shifted below the mantissa

package Functions;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

module int_normalize_pipe #(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 24
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  inValid,
    output logic                                  inReady,
    input  logic [WIDTH-1:0]                      inData,
    output logic                                  outValid,
    input  logic                                  outReady,
    output logic                                  outZero,
    output logic [Functions::clog2(WIDTH+1)-1:0]  outLzc,
    output logic [OUT_WIDTH-1:0]                  outMant,
    output logic                                  outSticky
);

    localparam int LZC_BITS = Functions::clog2(WIDTH + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WIDTH < 2 || WIDTH > 1024) begin : g_bad_width
        $error("int_normalize_pipe: WIDTH=%0d outside 2..1024", WIDTH);
    end

    if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out_width
        $error("int_normalize_pipe: OUT_WIDTH=%0d outside 1..WIDTH", OUT_WIDTH);
    end

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic                 v1;
    logic                 v2;
    logic                 v3;

    logic [WIDTH-1:0]     d1;

    logic [WIDTH-1:0]     d2;
    logic [LZC_BITS-1:0]  lzc2;

    logic                 zero3;
    logic [LZC_BITS-1:0]  lzc3;
    logic [OUT_WIDTH-1:0] mant3;
    logic                 sticky3;

    // ------------------------------------------------------------------
    // Advance chain: a stage may load when it is empty or when the stage
    // after it is moving, so bubbles collapse instead of stalling input.
    // ------------------------------------------------------------------
    logic adv1;
    logic adv2;
    logic adv3;

    assign adv3    = !v3 || outReady;
    assign adv2    = !v2 || adv3;
    assign adv1    = !v1 || adv2;
    assign inReady = adv1;

    // ------------------------------------------------------------------
    // S2 combinational: leading-zero count of the S1 word.
    // Scanning upward lets the highest set bit win; an all-zero word
    // keeps the default of WIDTH.
    // ------------------------------------------------------------------
    logic [LZC_BITS-1:0] lzc1;

    always_comb begin
        lzc1 = LZC_BITS'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d1[i]) begin
                lzc1 = LZC_BITS'(WIDTH - 1 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: normalize by the registered count.
    // A zero word has count WIDTH, which shifts everything out and
    // therefore yields mantissa 0 and sticky 0 without special casing.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     shifted2;
    logic [OUT_WIDTH-1:0] mant_next;
    logic                 sticky_next;
    logic                 zero_next;

    assign shifted2  = d2 << lzc2;
    assign mant_next = shifted2[WIDTH-1 -: OUT_WIDTH];
    assign zero_next = (lzc2 == LZC_BITS'(WIDTH));

    if (OUT_WIDTH < WIDTH) begin : g_sticky
        assign sticky_next = |shifted2[WIDTH-OUT_WIDTH-1:0];
    end else begin : g_no_sticky
        // Mantissa spans the whole word: nothing can fall below it.
        assign sticky_next = 1'b0;
    end

    // ------------------------------------------------------------------
    // S1: capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (adv1) begin
            v1 <= inValid;
            if (inValid) begin
                d1 <= inData;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: count
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v2   <= 1'b0;
            d2   <= '0;
            lzc2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                d2   <= d1;
                lzc2 <= lzc1;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: shift and present
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v3      <= 1'b0;
            zero3   <= 1'b0;
            lzc3    <= '0;
            mant3   <= '0;
            sticky3 <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                zero3   <= zero_next;
                lzc3    <= lzc2;
                mant3   <= mant_next;
                sticky3 <= sticky_next;
            end
        end
    end

    assign outValid  = v3;
    assign outZero   = zero3;
    assign outLzc    = lzc3;
    assign outMant   = mant3;
    assign outSticky = sticky3;

endmodule

// File: tb/tb_int_normalize_pipe.sv
module tb_int_normalize_pipe;

    localparam int W  = 64;
    localparam int OW = 24;
    localparam int LB = 7;

    typedef struct packed {
        logic          zero;
        logic [LB-1:0] lzc;
        logic [OW-1:0] mant;
        logic          sticky;
    } res_t;

    logic          clock;
    logic          resetn;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic          outValid;
    logic          outReady;
    logic          outZero;
    logic [LB-1:0] outLzc;
    logic [OW-1:0] outMant;
    logic          outSticky;

    int   checks;
    int   errors;
    int   stalls;
    logic rand_done;
    res_t sb[$];
    res_t mon_got;
    res_t mon_exp;
    res_t hold;

    int_normalize_pipe #(
        .WIDTH     (W),
        .OUT_WIDTH (OW)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outZero   (outZero),
        .outLzc    (outLzc),
        .outMant   (outMant),
        .outSticky (outSticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic z, input int lzc, input logic [OW-1:0] m, input logic s);
        res_t r;
        r.zero   = z;
        r.lzc    = LB'(lzc);
        r.mant   = m;
        r.sticky = s;
        return r;
    endfunction

    // Reference: walk the word left one bit at a time until its MSB is set.
    function automatic res_t ref_model(input logic [W-1:0] d);
        logic [W-1:0] x;
        int           n;
        if (d == '0) return mk(1'b1, W, '0, 1'b0);
        x = d;
        n = 0;
        while (x[W-1] == 1'b0) begin
            x = x << 1;
            n++;
        end
        return mk(1'b0, n, x[W-1:W-OW], |x[W-OW-1:0]);
    endfunction

    // Drive one word; push its expected result once the handshake is seen.
    task automatic send(input logic [W-1:0] d, input res_t e);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        inValid = 1'b1;
        inData  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (inReady) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: inReady stayed 0 for data 0x%0h", d);
            inValid = 1'b0;
            return;
        end
        sb.push_back(e);
        stalls += n;
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        outReady = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_valid", 64'(outValid), 64'd0);
    endtask

    // Scoreboard monitor: compares on every output transfer.
    always @(negedge clock) begin
        if (resetn && outValid && outReady) begin
            mon_got = {outZero, outLzc, outMant, outSticky};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                check("result", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        stalls    = 0;
        rand_done = 1'b0;
        resetn    = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        outReady  = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid",  64'(outValid),  64'd0);
        check("rst_zero",   64'(outZero),   64'd0);
        check("rst_lzc",    64'(outLzc),    64'd0);
        check("rst_mant",   64'(outMant),   64'd0);
        check("rst_sticky", 64'(outSticky), 64'd0);
        @(posedge clock);
        #1;
        resetn   = 1'b1;
        outReady = 1'b1;
        @(negedge clock);
        check("rst_inready", 64'(inReady), 64'd1);
        @(posedge clock);
        #1;

        // Latency: accepted at edge N, valid after edge N+2
        send(64'h1, mk(1'b0, 63, 24'h800000, 1'b0));
        @(negedge clock);
        check("lat_n0", 64'(outValid), 64'd0);
        @(negedge clock);
        check("lat_n1", 64'(outValid), 64'd0);
        @(negedge clock);
        check("lat_n2", 64'(outValid), 64'd1);
        @(posedge clock);
        #1;

        // Directed patterns back-to-back at full rate
        stalls = 0;
        send(64'h0,                  mk(1'b1, 64, 24'h000000, 1'b0));
        send(64'h8000_0000_0000_0001, mk(1'b0, 0,  24'h800000, 1'b1));
        send(64'h0000_0000_00FF_FFFF, mk(1'b0, 40, 24'hFFFFFF, 1'b0));
        send(64'hFFFF_FFFF_FFFF_FFFF, mk(1'b0, 0,  24'hFFFFFF, 1'b1));
        send(64'h0000_0100_0000_0001, mk(1'b0, 23, 24'h800000, 1'b1));
        send(64'h0000_0000_0100_0000, mk(1'b0, 39, 24'h800000, 1'b0));
        send(64'h0000_0000_01FF_FFFF, mk(1'b0, 39, 24'hFFFFFF, 1'b1));
        check("throughput_stalls", 64'(stalls), 64'd0);
        drain();

        // Backpressure: fill the pipe with outReady low
        @(posedge clock);
        #1;
        outReady = 1'b0;
        send(64'd1, mk(1'b0, 63, 24'h800000, 1'b0));
        send(64'd2, mk(1'b0, 62, 24'h800000, 1'b0));
        send(64'd3, mk(1'b0, 62, 24'hC00000, 1'b0));
        inValid = 1'b1;
        inData  = 64'd4;
        @(negedge clock);
        check("full_inready", 64'(inReady), 64'd0);
        hold = {outZero, outLzc, outMant, outSticky};
        check("stall_head", 64'(hold), 64'(mk(1'b0, 63, 24'h800000, 1'b0)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall_stable", 64'({outZero, outLzc, outMant, outSticky}), 64'(hold));
            check("stall_valid",  64'(outValid), 64'd1);
            check("stall_inready", 64'(inReady), 64'd0);
        end
        @(posedge clock);
        #1;
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clock);
        check("same_cycle_inready", 64'(inReady), 64'd1);
        @(posedge clock);
        #1;
        send(64'd4, mk(1'b0, 61, 24'h800000, 1'b0));
        send(64'd5, mk(1'b0, 61, 24'hA00000, 1'b0));
        drain();

        // Random bubbles on both sides against the reference model
        @(posedge clock);
        #1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [W-1:0] d;
                    d = {$urandom, $urandom} >> $urandom_range(0, 64);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                    send(d, ref_model(d));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    outReady = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Reset mid-flight discards everything
        @(posedge clock);
        #1;
        outReady = 1'b0;
        send(64'h10, mk(1'b0, 59, 24'h800000, 1'b0));
        send(64'h20, mk(1'b0, 58, 24'h800000, 1'b0));
        send(64'h30, mk(1'b0, 58, 24'hC00000, 1'b0));
        resetn = 1'b0;
        #1;
        check("midrst_valid",  64'(outValid),  64'd0);
        check("midrst_zero",   64'(outZero),   64'd0);
        check("midrst_lzc",    64'(outLzc),    64'd0);
        check("midrst_mant",   64'(outMant),   64'd0);
        check("midrst_sticky", 64'(outSticky), 64'd0);
        sb.delete();
        @(posedge clock);
        #1;
        resetn   = 1'b1;
        outReady = 1'b1;
        send(64'h40, mk(1'b0, 57, 24'h800000, 1'b0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
